// File: rtl/mem_miss_arbiter_pkg.sv
// rtl/mem_miss_arbiter_pkg.sv - shared types and widths for the I$/D$ miss arbiter
package mem_miss_arbiter_pkg;

    localparam int THR_W                   = 2;
    localparam int NTHR                    = 4;
    localparam int LINE_W                  = 128;
    localparam int MEM_ARB_TIMEOUT_DEFAULT = 1024;

    typedef struct packed {
        logic [31:0] addr;
        logic        is_evict;
    } memory_request_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_RSP
    } mem_arb_state_t;

    typedef enum logic {
        OWNER_ICACHE,
        OWNER_DCACHE
    } mem_arb_owner_t;

    function automatic mem_arb_owner_t other_owner(input mem_arb_owner_t o);
        return (o == OWNER_ICACHE) ? OWNER_DCACHE : OWNER_ICACHE;
    endfunction

endpackage

// File: rtl/mem_miss_arbiter_if.sv
// rtl/mem_miss_arbiter_if.sv - cache-side and memory-side signal bundle of the miss arbiter
interface mem_miss_arbiter_if import mem_miss_arbiter_pkg::*; ();

    logic [NTHR-1:0]   flush;
    logic              icache_req_valid;
    memory_request_t   icache_req_info;
    logic [THR_W-1:0]  icache_req_thread_id;
    logic              dcache_req_valid;
    memory_request_t   dcache_req_info;
    logic [THR_W-1:0]  dcache_req_thread_id;
    logic              icache_pending;
    logic              dcache_pending;
    logic              mem_req_valid;
    memory_request_t   mem_req_info;
    logic [THR_W-1:0]  mem_req_thread_id;
    logic              mem_req_ready;
    logic              mem_rsp_valid;
    logic [LINE_W-1:0] mem_rsp_data;
    logic              mem_rsp_bus_error;
    logic              icache_rsp_valid;
    logic [LINE_W-1:0] icache_rsp_data;
    logic [THR_W-1:0]  icache_rsp_thread_id;
    logic              icache_rsp_bus_error;
    logic              dcache_rsp_valid;
    logic [LINE_W-1:0] dcache_rsp_data;
    logic [THR_W-1:0]  dcache_rsp_thread_id;
    logic              dcache_rsp_bus_error;
    logic              req_overflow;

    modport master (
        input  flush, icache_req_valid, icache_req_info, icache_req_thread_id,
               dcache_req_valid, dcache_req_info, dcache_req_thread_id,
               mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_bus_error,
        output icache_pending, dcache_pending, mem_req_valid, mem_req_info, mem_req_thread_id,
               icache_rsp_valid, icache_rsp_data, icache_rsp_thread_id, icache_rsp_bus_error,
               dcache_rsp_valid, dcache_rsp_data, dcache_rsp_thread_id, dcache_rsp_bus_error,
               req_overflow
    );

    modport slave (
        output flush, icache_req_valid, icache_req_info, icache_req_thread_id,
               dcache_req_valid, dcache_req_info, dcache_req_thread_id,
               mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_bus_error,
        input  icache_pending, dcache_pending, mem_req_valid, mem_req_info, mem_req_thread_id,
               icache_rsp_valid, icache_rsp_data, icache_rsp_thread_id, icache_rsp_bus_error,
               dcache_rsp_valid, dcache_rsp_data, dcache_rsp_thread_id, dcache_rsp_bus_error,
               req_overflow
    );

endinterface

// File: rtl/mem_arb_slot.sv
// rtl/mem_arb_slot.sv - one-deep pending request slot with flush squash and overflow pulse
module mem_arb_slot import mem_miss_arbiter_pkg::*; (
    input  logic             clock,
    input  logic             reset,
    input  logic [NTHR-1:0]  flush,
    input  logic             req_valid,
    input  memory_request_t  req_info,
    input  logic [THR_W-1:0] req_thread_id,
    input  logic             grant,
    input  logic             free,
    output logic             pending,
    output logic             eligible,
    output memory_request_t  info,
    output logic [THR_W-1:0] thread_id,
    output logic             overflow
);

    logic granted;

    // A slot whose thread is being flushed this cycle must not win arbitration.
    assign eligible = pending && !granted && !flush[thread_id];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending   <= 1'b0;
            granted   <= 1'b0;
            info      <= '0;
            thread_id <= '0;
            overflow  <= 1'b0;
        end else begin
            overflow <= req_valid && pending;
            if (free) begin
                pending <= 1'b0;
                granted <= 1'b0;
            end else if (pending && !granted && flush[thread_id]) begin
                pending <= 1'b0;
            end else if (grant) begin
                granted <= 1'b1;
            end
            if (req_valid && !pending && !flush[req_thread_id]) begin
                pending   <= 1'b1;
                info      <= req_info;
                thread_id <= req_thread_id;
            end
        end
    end

endmodule

// File: rtl/mem_miss_arbiter.sv
// rtl/mem_miss_arbiter.sv - round-robin I$/D$ miss arbiter onto one memory port; MEM_MISS_ARB_TIMEOUT_EN adds a response watchdog
module mem_miss_arbiter import mem_miss_arbiter_pkg::*;
`ifdef MEM_MISS_ARB_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYCLES = MEM_ARB_TIMEOUT_DEFAULT
)
`endif
(
    input logic clock,
    input logic reset,
    mem_miss_arbiter_if.master bus
);

    mem_arb_state_t   state;
    mem_arb_owner_t   owner, rr_ptr, pick;
    logic             squashed, pick_valid, done, timed_out, owner_flush;
    logic             elig_i, elig_d, grant_i, grant_d, free_i, free_d, ovf_i, ovf_d;
    memory_request_t  info_i, info_d;
    logic [THR_W-1:0] tid_i, tid_d;
    logic [LINE_W-1:0] rsp_line;
    logic             rsp_err;

    mem_arb_slot u_islot (
        .clock(clock), .reset(reset), .flush(bus.flush),
        .req_valid(bus.icache_req_valid), .req_info(bus.icache_req_info),
        .req_thread_id(bus.icache_req_thread_id), .grant(grant_i), .free(free_i),
        .pending(bus.icache_pending), .eligible(elig_i), .info(info_i),
        .thread_id(tid_i), .overflow(ovf_i)
    );

    mem_arb_slot u_dslot (
        .clock(clock), .reset(reset), .flush(bus.flush),
        .req_valid(bus.dcache_req_valid), .req_info(bus.dcache_req_info),
        .req_thread_id(bus.dcache_req_thread_id), .grant(grant_d), .free(free_d),
        .pending(bus.dcache_pending), .eligible(elig_d), .info(info_d),
        .thread_id(tid_d), .overflow(ovf_d)
    );

    always_comb begin
        pick_valid = elig_i || elig_d;
        if (elig_i && elig_d)
            pick = rr_ptr;
        else if (elig_d)
            pick = OWNER_DCACHE;
        else
            pick = OWNER_ICACHE;
    end

`ifdef MEM_MISS_ARB_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMR_W-1:0] timer;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            timer <= '0;
        else if (state == WAIT_RSP)
            timer <= timer + 1'b1;
        else
            timer <= '0;
    end

    // Fires on the cycle the counter would reach the limit, so the pulse lands TIMEOUT_CYCLES after entry.
    assign timed_out = (timer == TMR_W'(TIMEOUT_CYCLES - 1));
`else
    assign timed_out = 1'b0;
`endif

    assign owner_flush      = bus.flush[bus.mem_req_thread_id];
    assign done             = (state == WAIT_RSP) && (bus.mem_rsp_valid || timed_out);
    assign rsp_line         = bus.mem_rsp_valid ? bus.mem_rsp_data : '0;
    assign rsp_err          = bus.mem_rsp_valid ? bus.mem_rsp_bus_error : 1'b1;
    assign grant_i          = (state == IDLE) && pick_valid && (pick == OWNER_ICACHE);
    assign grant_d          = (state == IDLE) && pick_valid && (pick == OWNER_DCACHE);
    assign free_i           = done && (owner == OWNER_ICACHE);
    assign free_d           = done && (owner == OWNER_DCACHE);
    assign bus.req_overflow = ovf_i || ovf_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state                    <= IDLE;
            owner                    <= OWNER_ICACHE;
            rr_ptr                   <= OWNER_DCACHE;
            squashed                 <= 1'b0;
            bus.mem_req_valid        <= 1'b0;
            bus.mem_req_info         <= '0;
            bus.mem_req_thread_id    <= '0;
            bus.icache_rsp_valid     <= 1'b0;
            bus.icache_rsp_data      <= '0;
            bus.icache_rsp_thread_id <= '0;
            bus.icache_rsp_bus_error <= 1'b0;
            bus.dcache_rsp_valid     <= 1'b0;
            bus.dcache_rsp_data      <= '0;
            bus.dcache_rsp_thread_id <= '0;
            bus.dcache_rsp_bus_error <= 1'b0;
        end else begin
            bus.icache_rsp_valid <= 1'b0;
            bus.dcache_rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        owner                 <= pick;
                        squashed              <= 1'b0;
                        bus.mem_req_valid     <= 1'b1;
                        bus.mem_req_info      <= (pick == OWNER_DCACHE) ? info_d : info_i;
                        bus.mem_req_thread_id <= (pick == OWNER_DCACHE) ? tid_d : tid_i;
                        if (elig_i && elig_d)
                            rr_ptr <= other_owner(pick);
                        state <= REQ;
                    end
                end
                REQ: begin
                    // The request is never retracted; a flush only suppresses the eventual response.
                    if (owner_flush)
                        squashed <= 1'b1;
                    if (bus.mem_req_ready) begin
                        bus.mem_req_valid <= 1'b0;
                        state             <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    if (done) begin
                        state <= IDLE;
                        if (!(squashed || owner_flush)) begin
                            if (owner == OWNER_ICACHE) begin
                                bus.icache_rsp_valid     <= 1'b1;
                                bus.icache_rsp_data      <= rsp_line;
                                bus.icache_rsp_thread_id <= bus.mem_req_thread_id;
                                bus.icache_rsp_bus_error <= rsp_err;
                            end else begin
                                bus.dcache_rsp_valid     <= 1'b1;
                                bus.dcache_rsp_data      <= rsp_line;
                                bus.dcache_rsp_thread_id <= bus.mem_req_thread_id;
                                bus.dcache_rsp_bus_error <= rsp_err;
                            end
                        end
                    end else if (owner_flush) begin
                        squashed <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_miss_arbiter.sv
// tb/tb_mem_miss_arbiter.sv - directed and randomized self-checking bench for mem_miss_arbiter
module tb_mem_miss_arbiter;
    import mem_miss_arbiter_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    mem_miss_arbiter_if bus();
    mem_miss_arbiter dut (.clock(clock), .reset(reset), .bus(bus));

    int n_tests = 0, n_fail = 0;
    int i_cnt = 0, d_cnt = 0, ovf_cnt = 0;
    logic [31:0] hs_addr[$];

    // Reference: two request slots, one shared port, round-robin on contention only.
    bit m_busy[2], m_granted[2], m_squash;
    memory_request_t m_info[2];
    logic [THR_W-1:0] m_tid[2];
    int m_port, m_cur, m_prefer;
    bit e_mem_v, e_ovf;
    memory_request_t e_mem_info;
    logic [THR_W-1:0] e_mem_tid;
    bit e_rsp_v[2], e_rsp_err[2];
    logic [LINE_W-1:0] e_rsp_data[2];
    logic [THR_W-1:0] e_rsp_tid[2];

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_init();
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 0; m_granted[k] = 0; m_info[k] = '0; m_tid[k] = '0;
            e_rsp_v[k] = 0; e_rsp_err[k] = 0; e_rsp_data[k] = '0; e_rsp_tid[k] = '0;
        end
        m_port = 0; m_cur = 0; m_prefer = 1; m_squash = 0;
        e_mem_v = 0; e_mem_info = '0; e_mem_tid = '0; e_ovf = 0;
    endtask

    task automatic model_step();
        bit pre_busy[2], pre_gr[2], elig[2], rq[2];
        memory_request_t ri[2];
        logic [THR_W-1:0] rt[2];
        int w;
        rq[0] = bus.icache_req_valid; ri[0] = bus.icache_req_info; rt[0] = bus.icache_req_thread_id;
        rq[1] = bus.dcache_req_valid; ri[1] = bus.dcache_req_info; rt[1] = bus.dcache_req_thread_id;
        for (int k = 0; k < 2; k++) begin
            pre_busy[k] = m_busy[k]; pre_gr[k] = m_granted[k]; e_rsp_v[k] = 0;
            elig[k] = m_busy[k] && !m_granted[k] && !bus.flush[m_tid[k]];
        end
        e_ovf = (rq[0] && pre_busy[0]) || (rq[1] && pre_busy[1]);
        if (m_port == 0) begin
            if (elig[0] || elig[1]) begin
                w = (elig[0] && elig[1]) ? m_prefer : (elig[1] ? 1 : 0);
                if (elig[0] && elig[1]) m_prefer = 1 - w;
                m_cur = w; m_granted[w] = 1; m_squash = 0;
                e_mem_v = 1; e_mem_info = m_info[w]; e_mem_tid = m_tid[w]; m_port = 1;
            end
        end else if (m_port == 1) begin
            if (bus.flush[e_mem_tid]) m_squash = 1;
            if (bus.mem_req_ready) begin e_mem_v = 0; m_port = 2; end
        end else begin
            if (bus.mem_rsp_valid) begin
                if (!(m_squash || bus.flush[e_mem_tid])) begin
                    e_rsp_v[m_cur] = 1; e_rsp_data[m_cur] = bus.mem_rsp_data;
                    e_rsp_tid[m_cur] = e_mem_tid; e_rsp_err[m_cur] = bus.mem_rsp_bus_error;
                end
                m_busy[m_cur] = 0; m_granted[m_cur] = 0; m_port = 0;
            end else if (bus.flush[e_mem_tid]) begin
                m_squash = 1;
            end
        end
        for (int k = 0; k < 2; k++) begin
            if (pre_busy[k] && !pre_gr[k] && bus.flush[m_tid[k]]) m_busy[k] = 0;
            if (rq[k] && !pre_busy[k] && !bus.flush[rt[k]]) begin
                m_busy[k] = 1; m_info[k] = ri[k]; m_tid[k] = rt[k];
            end
        end
    endtask

    task automatic check_outputs();
        check("icache_pending", bus.icache_pending, m_busy[0]);
        check("dcache_pending", bus.dcache_pending, m_busy[1]);
        check("req_overflow", bus.req_overflow, e_ovf);
        check("mem_req_valid", bus.mem_req_valid, e_mem_v);
        if (e_mem_v) begin
            check("mem_req_info", bus.mem_req_info, e_mem_info);
            check("mem_req_thread_id", bus.mem_req_thread_id, e_mem_tid);
        end
        check("icache_rsp_valid", bus.icache_rsp_valid, e_rsp_v[0]);
        if (e_rsp_v[0]) begin
            check("icache_rsp_data", bus.icache_rsp_data, e_rsp_data[0]);
            check("icache_rsp_thread_id", bus.icache_rsp_thread_id, e_rsp_tid[0]);
            check("icache_rsp_bus_error", bus.icache_rsp_bus_error, e_rsp_err[0]);
        end
        check("dcache_rsp_valid", bus.dcache_rsp_valid, e_rsp_v[1]);
        if (e_rsp_v[1]) begin
            check("dcache_rsp_data", bus.dcache_rsp_data, e_rsp_data[1]);
            check("dcache_rsp_thread_id", bus.dcache_rsp_thread_id, e_rsp_tid[1]);
            check("dcache_rsp_bus_error", bus.dcache_rsp_bus_error, e_rsp_err[1]);
        end
    endtask

    task automatic tick();
        if (bus.mem_req_valid && bus.mem_req_ready) hs_addr.push_back(bus.mem_req_info.addr);
        @(posedge clock);
        if (!reset) model_init(); else model_step();
        @(negedge clock);
        check_outputs();
        i_cnt += int'(bus.icache_rsp_valid);
        d_cnt += int'(bus.dcache_rsp_valid);
        ovf_cnt += int'(bus.req_overflow);
    endtask

    task automatic idle_inputs();
        bus.flush = '0;
        bus.icache_req_valid = 0; bus.icache_req_info = '0; bus.icache_req_thread_id = '0;
        bus.dcache_req_valid = 0; bus.dcache_req_info = '0; bus.dcache_req_thread_id = '0;
        bus.mem_req_ready = 0; bus.mem_rsp_valid = 0; bus.mem_rsp_data = '0; bus.mem_rsp_bus_error = 0;
    endtask

    task automatic req_i(input logic [31:0] a, input logic [THR_W-1:0] t);
        bus.icache_req_valid = 1; bus.icache_req_info = '{addr: a, is_evict: 1'b0}; bus.icache_req_thread_id = t;
    endtask

    task automatic req_d(input logic [31:0] a, input logic [THR_W-1:0] t);
        bus.dcache_req_valid = 1; bus.dcache_req_info = '{addr: a, is_evict: 1'b1}; bus.dcache_req_thread_id = t;
    endtask

    initial begin
        int base, c0, c1;
        model_init();
        idle_inputs();
        tick(); tick();
        check("rst_mem_req_valid", bus.mem_req_valid, 0);
        check("rst_mem_req_info", bus.mem_req_info, 0);
        check("rst_pending", {bus.icache_pending, bus.dcache_pending}, 0);
        check("rst_rsp_data", {bus.icache_rsp_data, bus.dcache_rsp_data}, 0);
        check("rst_overflow", bus.req_overflow, 0);
        reset = 1;

        // single D$ miss, minimum round trip
        idle_inputs(); bus.mem_req_ready = 1; req_d(32'h1000, 2'd1);
        tick(); bus.dcache_req_valid = 0;
        tick(); check("t1_req_addr", bus.mem_req_info.addr, 32'h1000);
        tick(); bus.mem_rsp_valid = 1; bus.mem_rsp_data = {16{8'hA5}};
        tick(); bus.mem_rsp_valid = 0;
        check("t1_d_rsp_valid", bus.dcache_rsp_valid, 1);
        check("t1_d_rsp_data", bus.dcache_rsp_data, {16{8'hA5}});
        check("t1_d_rsp_tid", bus.dcache_rsp_thread_id, 1);
        check("t1_d_rsp_err", bus.dcache_rsp_bus_error, 0);
        check("t1_i_rsp_valid", bus.icache_rsp_valid, 0);
        tick(); check("t1_d_rsp_pulse_end", bus.dcache_rsp_valid, 0);

        // contention: D$ first after reset, then I$ first
        base = hs_addr.size();
        idle_inputs(); bus.mem_req_ready = 1; bus.mem_rsp_valid = 1; bus.mem_rsp_data = {4{32'h1234_5678}};
        req_i(32'h2000, 2'd2); req_d(32'h3000, 2'd3);
        tick(); bus.icache_req_valid = 0; bus.dcache_req_valid = 0;
        repeat (16) tick();
        req_i(32'h4000, 2'd0); req_d(32'h5000, 2'd1);
        tick(); bus.icache_req_valid = 0; bus.dcache_req_valid = 0;
        repeat (16) tick();
        check("t2_hs_count", hs_addr.size() - base, 4);
        check("t2_first", hs_addr[base], 32'h3000);
        check("t2_second", hs_addr[base+1], 32'h2000);
        check("t2_third", hs_addr[base+2], 32'h4000);
        check("t2_fourth", hs_addr[base+3], 32'h5000);

        // overflow on a full D$ slot
        base = hs_addr.size(); c0 = ovf_cnt;
        req_d(32'h6000, 2'd2); tick();
        req_d(32'h6100, 2'd2); tick();
        bus.dcache_req_valid = 0;
        repeat (14) tick();
        check("t3_overflow_pulses", ovf_cnt - c0, 1);
        check("t3_hs_count", hs_addr.size() - base, 1);

        // flush in WAIT_RSP squashes the response
        idle_inputs(); bus.mem_req_ready = 1; c0 = i_cnt;
        req_i(32'h6800, 2'd0); tick(); bus.icache_req_valid = 0;
        tick(); tick();
        bus.flush = 4'b0001; tick();
        bus.flush = '0; bus.mem_rsp_valid = 1; tick();
        bus.mem_rsp_valid = 0; repeat (4) tick();
        check("t4_squashed_rsp", i_cnt - c0, 0);
        check("t4_pending_clear", bus.icache_pending, 0);
        c0 = i_cnt; bus.mem_rsp_valid = 1;
        req_i(32'h6900, 2'd0); tick(); bus.icache_req_valid = 0;
        repeat (8) tick();
        check("t4_next_served", i_cnt - c0, 1);

        // ready held low: request stable, responses in REQ ignored
        idle_inputs(); bus.mem_rsp_valid = 1; c0 = i_cnt;
        req_i(32'h7000, 2'd1); tick(); bus.icache_req_valid = 0;
        tick();
        for (int k = 0; k < 5; k++) begin
            check("t5_valid_stable", bus.mem_req_valid, 1);
            check("t5_addr_stable", bus.mem_req_info.addr, 32'h7000);
            check("t5_tid_stable", bus.mem_req_thread_id, 1);
            tick();
        end
        check("t5_no_rsp_in_req", i_cnt - c0, 0);
        bus.mem_req_ready = 1; tick(); tick(); tick();
        check("t5_rsp_after_ready", i_cnt - c0, 1);

        // randomized traffic against the reference, with one mid-run reset
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                idle_inputs(); reset = 0; #1;
                check("async_rst_mem_req_valid", bus.mem_req_valid, 0);
                check("async_rst_pending", {bus.icache_pending, bus.dcache_pending}, 0);
                tick(); tick();
                reset = 1; bus.mem_rsp_valid = 1; c1 = i_cnt + d_cnt;
                tick(); tick();
                check("late_rsp_ignored", i_cnt + d_cnt - c1, 0);
            end
            bus.icache_req_valid = ($urandom % 4 == 0);
            bus.icache_req_info = '{addr: $urandom, is_evict: 1'($urandom % 2)};
            bus.icache_req_thread_id = THR_W'($urandom_range(NTHR-1, 0));
            bus.dcache_req_valid = ($urandom % 4 == 0);
            bus.dcache_req_info = '{addr: $urandom, is_evict: 1'($urandom % 2)};
            bus.dcache_req_thread_id = THR_W'($urandom_range(NTHR-1, 0));
            bus.flush = ($urandom % 12 == 0) ? NTHR'(1 << $urandom_range(NTHR-1, 0)) : '0;
            bus.mem_req_ready = 1'($urandom % 2);
            bus.mem_rsp_valid = ($urandom % 3 == 0);
            bus.mem_rsp_data = {$urandom, $urandom, $urandom, $urandom};
            bus.mem_rsp_bus_error = 1'($urandom % 2);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
